// File: rtl/test_src_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_src_pkg
// Description : Shared types and constants for the test data source.
// Revision    : 1.0 - initial release
// ============================================================================
package test_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_DIP   = 2'd0,
        MODE_CNT   = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_FIXED = 2'd3
    } mode_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;
    localparam logic [7:0]  c_FILL_BYTE = 8'hA5;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ c_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_src_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : test_src_lfsr
// Description : 32-bit Galois LFSR that steps once per cycle with i_adv high.
// Revision    : 1.0 - initial release
// ============================================================================
module test_src_lfsr
    import test_src_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adv,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_adv) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/test_data_src.sv
`default_nettype none
// ============================================================================
// Module      : test_data_src
// Description : Burst-oriented test pattern source (DIP, counter, LFSR, fill).
// Revision    : 1.0 - initial release
// ============================================================================
module test_data_src
    import test_src_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DIP_W     = 8,
    parameter int          BURST_MAX = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DIP_W-1:0]                     GPIO_DIP,
    input  logic [1:0]                           mode,
    input  logic [$clog2(BURST_MAX+1)-1:0]       burst_len,
    input  logic                                 rdy_for_data,
    output logic                                 data_rdy,
    output logic [DATA_W-1:0]                    data_in,
    output logic                                 busy,
    output logic [15:0]                          words_sent
);

    localparam int              LEN_W       = $clog2(BURST_MAX + 1);
    localparam logic [LEN_W-1:0] c_BURST_MAX = LEN_W'(BURST_MAX);

    state_t              r_state;
    mode_t               r_mode;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_index;
    logic [DATA_W-1:0]   r_counter;
    logic [15:0]         r_words_sent;
    logic                r_data_rdy;
    logic                r_busy;

    logic                w_xfer;
    logic [LEN_W-1:0]    w_eff_len;
    logic [31:0]         w_lfsr;
    logic [7:0]          w_idx8;
    logic [DATA_W-1:0]   w_dip_word;
    logic [DATA_W-1:0]   w_fill_word;
    logic [DATA_W-1:0]   w_word;

    // r_data_rdy mirrors ST_SEND, so a transfer needs no decode of the state
    assign w_xfer = r_data_rdy & rdy_for_data;

    always_comb begin
        w_eff_len = burst_len;
        if (burst_len == '0) begin
            w_eff_len = LEN_W'(1);
        end else if (burst_len > c_BURST_MAX) begin
            w_eff_len = c_BURST_MAX;
        end
    end

    test_src_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_xfer && (r_mode == MODE_LFSR)),
        .o_state (w_lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_DIP;
            r_len        <= '0;
            r_index      <= '0;
            r_counter    <= '0;
            r_words_sent <= '0;
            r_data_rdy   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rdy_for_data) begin
                        r_state    <= ST_SEND;
                        r_mode     <= mode_t'(mode);
                        r_len      <= w_eff_len;
                        r_index    <= '0;
                        r_data_rdy <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (rdy_for_data) begin
                        r_words_sent <= r_words_sent + 16'd1;
                        if (r_mode == MODE_CNT) begin
                            r_counter <= r_counter + DATA_W'(1);
                        end
                        if (r_index == r_len - LEN_W'(1)) begin
                            r_state    <= ST_HOLD;
                            r_index    <= '0;
                            r_data_rdy <= 1'b0;
                        end else begin
                            r_index <= r_index + LEN_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // One burst per ready assertion: wait for the consumer to drop ready
                    if (!rdy_for_data) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_data_rdy <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign w_idx8 = 8'(r_index);

    always_comb begin
        w_dip_word = '0;
        w_dip_word[DATA_W-1 -: DIP_W] = GPIO_DIP;
        w_dip_word[7:0] = w_idx8;
    end

    always_comb begin
        w_fill_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_fill_word[i] = c_FILL_BYTE[i % 8];
        end
    end

    always_comb begin
        w_word = '0;
        case (r_mode)
            MODE_DIP:   w_word = w_dip_word;
            MODE_CNT:   w_word = r_counter;
            MODE_LFSR:  w_word = DATA_W'(w_lfsr);
            MODE_FIXED: w_word = w_fill_word;
            default:    w_word = '0;
        endcase
    end

    assign data_in    = r_data_rdy ? w_word : '0;
    assign data_rdy   = r_data_rdy;
    assign busy       = r_busy;
    assign words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_test_data_src.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_data_src
// Description : Scoreboard bench for test_data_src with directed bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_data_src;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  GPIO_DIP;
    logic [1:0]  mode;
    logic [4:0]  burst_len;
    logic        rdy_for_data;
    logic        data_rdy;
    logic [31:0] data_in;
    logic        busy;
    logic [15:0] words_sent;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    test_data_src #(
        .DATA_W    (32),
        .DIP_W     (8),
        .BURST_MAX (16),
        .LFSR_SEED (32'hACE1_2468)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .GPIO_DIP     (GPIO_DIP),
        .mode         (mode),
        .burst_len    (burst_len),
        .rdy_for_data (rdy_for_data),
        .data_rdy     (data_rdy),
        .data_in      (data_in),
        .busy         (busy),
        .words_sent   (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every valid word is compared to the queue head; popped only on transfer
    always @(negedge clk) begin
        if (rst === 1'b0 && data_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %h expected none", data_in);
            end else begin
                check("word", data_in, exp_q[0]);
                if (rdy_for_data) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy_for_data = 1'b0;
        tick();
        tick();
        check("rst_data_rdy", data_rdy, 0);
        check("rst_data_in", data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_words_sent", words_sent, 0);
        rst = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic wait_hold_and_close(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy === 1'b1 && data_rdy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_hold_reached"}, ok, 1);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_hold_data_zero"}, data_in, 0);
        @(posedge clk);
        #1;
        check({name, "_stay_hold"}, busy, 1);
        rdy_for_data = 1'b0;
        tick();
        check({name, "_idle"}, busy, 0);
    endtask

    // Caller pushes expected words first; mode/burst_len are scrambled mid-burst
    task automatic burst(input string name, input logic [1:0] m, input logic [4:0] len);
        mode = m;
        burst_len = len;
        rdy_for_data = 1'b1;
        tick();
        mode = ~m;
        burst_len = 5'd1;
        wait_hold_and_close(name);
    endtask

    initial begin
        rst = 1'b1;
        rdy_for_data = 1'b0;
        mode = 2'd0;
        burst_len = 5'd0;
        GPIO_DIP = 8'h00;
        do_reset();

        GPIO_DIP = 8'h3C;
        exp_q.push_back(32'h3C00_0000);
        exp_q.push_back(32'h3C00_0001);
        exp_q.push_back(32'h3C00_0002);
        burst("dip", 2'd0, 5'd3);
        check("dip_words_sent", words_sent, 3);

        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        burst("cnt_a", 2'd1, 5'd4);
        for (int i = 4; i < 8; i++) exp_q.push_back(32'(i));
        burst("cnt_b", 2'd1, 5'd4);
        check("cnt_words_sent", words_sent, 8);

        exp_q.push_back(32'hA5A5_A5A5);
        burst("len_zero", 2'd3, 5'd0);
        check("len_zero_words_sent", words_sent, 9);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'hA5A5_A5A5);
        burst("len_sat", 2'd3, 5'd20);
        check("len_sat_words_sent", words_sent, 25);

        // LFSR burst with a two-cycle stall after the first word
        do_reset();
        exp_q.push_back(32'hACE1_2468);
        exp_q.push_back(32'h5670_9234);
        mode = 2'd2;
        burst_len = 5'd2;
        rdy_for_data = 1'b1;
        tick();
        tick();
        rdy_for_data = 1'b0;
        tick();
        tick();
        check("stall_data_rdy", data_rdy, 1);
        check("stall_held_word", data_in, 32'h5670_9234);
        check("stall_words_sent", words_sent, 1);
        rdy_for_data = 1'b1;
        wait_hold_and_close("lfsr");
        check("lfsr_words_sent", words_sent, 2);

        exp_q.push_back(32'h2B38_491A);
        exp_q.push_back(32'h159C_248D);
        exp_q.push_back(32'h8AEE_1245);
        exp_q.push_back(32'hC557_0921);
        burst("lfsr_cont", 2'd2, 5'd4);

        // Reset in the middle of a 5-word counter burst
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        burst("cnt_pre", 2'd1, 5'd2);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd4);
        mode = 2'd1;
        burst_len = 5'd5;
        rdy_for_data = 1'b1;
        tick();
        tick();
        tick();
        rdy_for_data = 1'b0;
        check("pre_rst_word", data_in, 32'd4);
        #1 rst = 1'b1;
        #1;
        check("async_rst_data_rdy", data_rdy, 0);
        check("async_rst_data_in", data_in, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_words_sent", words_sent, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        burst("cnt_post", 2'd1, 5'd2);
        check("cnt_post_words_sent", words_sent, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/test_data_src.md
TEST_DATA_SRC -- requirements
Module: test_data_src

Interface
REQ-001 Parameter DATA_W, default 32, output word width; legal range 16..64.
REQ-002 Parameter DIP_W, default 8, DIP input width; DIP_W <= DATA_W-8.
REQ-003 Parameter BURST_MAX, default 16, maximum words per burst.
REQ-004 Parameter LFSR_SEED, default 32'hACE1_2468, LFSR reset value; must be nonzero.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 GPIO_DIP  in  DIP_W  switch pattern.
REQ-008 mode  in  2  pattern select: 00 DIP, 01 counter, 10 LFSR, 11 fixed 0xA5 repeated.
REQ-009 burst_len  in  $clog2(BURST_MAX+1)  words per burst; 0 treated as 1; values above BURST_MAX saturate to BURST_MAX.
REQ-010 rdy_for_data  in  1  consumer ready (level).
REQ-011 data_rdy  out  1  word valid this cycle.
REQ-012 data_in  out  DATA_W  output word.
REQ-013 busy  out  1  high in SEND or HOLD.
REQ-014 words_sent  out  16  total accepted words since reset, wraps at 65535->0.

Function
REQ-015 FSM states IDLE, SEND, HOLD; state register only drives outputs (no input-to-data_rdy combinational path).
REQ-016 IDLE->SEND on any edge where rdy_for_data=1; mode and effective burst_len captured on that edge.
REQ-017 data_rdy SHALL equal (state==SEND); first word valid the cycle after rdy_for_data is sampled high (1-cycle latency).
REQ-018 Transfer occurs on an edge where data_rdy=1 and rdy_for_data=1; each transfer increments word index and words_sent.
REQ-019 In SEND with rdy_for_data=0: no transfer; data_in, index and generators hold (stall), state stays SEND.
REQ-020 On the transfer completing the burst (index = captured length-1): SEND->HOLD, index cleared.
REQ-021 HOLD->IDLE when rdy_for_data=0; HOLD stays while rdy_for_data=1 (one burst per ready assertion); data_rdy=0 in HOLD.
REQ-022 DIP mode: data_in = {GPIO_DIP live value, zeros, 8-bit word index} with DIP in MSBs, index in bits [7:0].
REQ-023 Counter mode: data_in = DATA_W-bit counter; advances by 1 per counter-mode transfer, persists across bursts, wraps 2^DATA_W-1 -> 0.
REQ-024 LFSR mode: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advances once per LFSR-mode transfer; data_in = LFSR zero-extended or truncated to DATA_W.
REQ-025 Fixed mode: data_in = 0xA5 replicated over DATA_W.
REQ-026 data_in SHALL be 0 whenever data_rdy=0.
REQ-027 Changes to mode/burst_len mid-burst have no effect until next IDLE->SEND.

Reset
REQ-028 rst asserted forces state IDLE, data_rdy=0, data_in=0, busy=0, words_sent=0, index=0, counter=0, LFSR=LFSR_SEED, immediately and regardless of clk.
REQ-029 Reset mid-burst discards the burst; after release, a new burst needs rdy_for_data sampled high in IDLE.

Structure
REQ-030 Package test_src_pkg holds state enum, mode enum, LFSR polynomial and 0xA5 fill constant.
REQ-031 One sub-module test_src_lfsr (advance enable, seed param, 32-bit state out); all else in test_data_src.

Verification
REQ-032 Reset, mode=00, GPIO_DIP=8'h3C, burst_len=3, hold rdy_for_data high -> three data_rdy cycles, data_in 0x3C000000/01/02, then HOLD, busy=1, data_rdy=0.
REQ-033 mode=01, burst_len=4 twice with rdy_for_data toggled between -> data_in 0..3 then 4..7; words_sent=8.
REQ-034 mode=10, burst_len=2 after reset -> first word 0xACE12468, second word = one Galois step of seed; rdy_for_data dropped 2 cycles mid-burst -> word held, no skip.
REQ-035 burst_len=0 -> exactly one word; burst_len above BURST_MAX -> exactly BURST_MAX words.
REQ-036 rst pulsed during word 2 of a 5-word counter burst -> outputs 0 asynchronously, counter restarts at 0 on next burst.
